// File: rtl/result_deskew.sv
// result_deskew
//
// Collects per-column results from the bottom edge of a systolic PE array,
// removes the diagonal skew (column j lags column 0 by j cycles) with one
// small FIFO per column, and hands off each aligned row vector on a
// valid/ready interface. A one-cycle rows_done pulse marks the handoff of
// the MATRIX_SIZE-th row of a matrix product.
//
// Optional feature: define DESKEW_OVF_EN to build the sticky overflow flag.
// Without it, ovf is tied low. Dropped pushes behave the same in both builds.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   reset      : asynchronous, active-low reset
//   start      : synchronous pulse, flush FIFOs and clear counters/flags
//                (out_data is held)
//   col_valid  : bit j qualifies column j of col_data this cycle
//   col_data   : slice j = [j*DATA_SIZE +: DATA_SIZE], column j result
//   out_valid  : aligned row available
//   out_ready  : consumer accepts the row when out_valid && out_ready
//   out_data   : aligned row, slice j taken from column j
//   rows_done  : one-cycle pulse after the MATRIX_SIZE-th row handshake
//   ovf        : sticky overflow flag (DESKEW_OVF_EN only, else 0)

module result_deskew #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [MATRIX_SIZE-1:0]           col_valid,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0] out_data,
    output logic                             rows_done,
    output logic                             ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ROW_W = $clog2(MATRIX_SIZE) + 1;
    localparam int OUT_W = MATRIX_SIZE * DATA_SIZE;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROWS_C  = ROW_W'(MATRIX_SIZE);

    // Column FIFO storage and bookkeeping
    logic [DATA_SIZE-1:0] mem_q    [MATRIX_SIZE][FIFO_DEPTH];
    logic [DATA_SIZE-1:0] mem_d    [MATRIX_SIZE][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [MATRIX_SIZE];
    logic [PTR_W-1:0]     wr_ptr_d [MATRIX_SIZE];
    logic [PTR_W-1:0]     rd_ptr_q [MATRIX_SIZE];
    logic [PTR_W-1:0]     rd_ptr_d [MATRIX_SIZE];
    logic [CNT_W-1:0]     count_q  [MATRIX_SIZE];
    logic [CNT_W-1:0]     count_d  [MATRIX_SIZE];

    // Output register and row tracking
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic [ROW_W-1:0] row_cnt_q,   row_cnt_d;
    logic             rows_done_q, rows_done_d;

    logic                   all_nonempty;
    logic                   pop_all;
    logic                   handshake;
    logic [MATRIX_SIZE-1:0] push_ok;

    always_comb begin
        all_nonempty = 1'b1;
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            if (count_q[j] == '0) all_nonempty = 1'b0;
        end
        // A row leaves only when every column has its element and the
        // output register is free (or being emptied this cycle).
        pop_all   = all_nonempty && (!out_valid_q || out_ready);
        handshake = out_valid_q && out_ready;

        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        push_ok     = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        row_cnt_d   = row_cnt_q;
        rows_done_d = 1'b0;

        if (start) begin
            // Flush everything except the last presented row data.
            for (int j = 0; j < MATRIX_SIZE; j++) begin
                wr_ptr_d[j] = '0;
                rd_ptr_d[j] = '0;
                count_d[j]  = '0;
            end
            out_valid_d = 1'b0;
            row_cnt_d   = '0;
        end else begin
            for (int j = 0; j < MATRIX_SIZE; j++) begin
                // A full FIFO still takes a push when it pops in the same cycle.
                push_ok[j] = col_valid[j] && ((count_q[j] != DEPTH_C) || pop_all);

                if (push_ok[j]) begin
                    mem_d[j][wr_ptr_q[j]] = col_data[j*DATA_SIZE +: DATA_SIZE];
                    wr_ptr_d[j]           = wr_ptr_q[j] + PTR_ONE;
                end
                if (pop_all) begin
                    out_data_d[j*DATA_SIZE +: DATA_SIZE] = mem_q[j][rd_ptr_q[j]];
                    rd_ptr_d[j]                          = rd_ptr_q[j] + PTR_ONE;
                end

                if (push_ok[j] && !pop_all) begin
                    count_d[j] = count_q[j] + CNT_ONE;
                end else if (!push_ok[j] && pop_all) begin
                    count_d[j] = count_q[j] - CNT_ONE;
                end
            end

            if (pop_all) begin
                out_valid_d = 1'b1;
            end else if (handshake) begin
                out_valid_d = 1'b0;
            end

            if (handshake) begin
                if (row_cnt_q + ROW_ONE == ROWS_C) begin
                    row_cnt_d   = '0;
                    rows_done_d = 1'b1;
                end else begin
                    row_cnt_d = row_cnt_q + ROW_ONE;
                end
            end
        end
    end

    // FIFO storage needs no reset: empty counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < MATRIX_SIZE; j++) begin
                wr_ptr_q[j] <= '0;
                rd_ptr_q[j] <= '0;
                count_q[j]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            row_cnt_q   <= '0;
            rows_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            row_cnt_q   <= row_cnt_d;
            rows_done_q <= rows_done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign rows_done = rows_done_q;

`ifdef DESKEW_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (start) begin
            ovf_d = 1'b0;
        end else if (|(col_valid & ~push_ok)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_result_deskew.sv
module tb_result_deskew;

    localparam int N     = 2;
    localparam int D     = 32;
    localparam int DEPTH = 4;
    localparam int W     = N * D;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic         start     = 1'b0;
    logic [N-1:0] col_valid = '0;
    logic [W-1:0] col_data  = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         rows_done;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one queue per column plus the presented row.
    logic [D-1:0] mq [N][$];
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_rows_done;
    logic         m_ovf;
    int           m_rows;

`ifdef DESKEW_OVF_EN
    localparam logic OVF_BUILD = 1'b1;
`else
    localparam logic OVF_BUILD = 1'b0;
`endif

    always #5 clk = ~clk;

    result_deskew #(
        .MATRIX_SIZE (N),
        .DATA_SIZE   (D),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .col_valid (col_valid),
        .col_data  (col_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rows_done (rows_done),
        .ovf       (ovf)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < N; j++) mq[j].delete();
        m_valid     = 1'b0;
        m_data      = '0;
        m_rows_done = 1'b0;
        m_ovf       = 1'b0;
        m_rows      = 0;
    endtask

    // One clock of the behavioural model: rows leave as whole vectors,
    // columns are plain bounded queues.
    task automatic model_clock(input logic [N-1:0] cv, input logic [W-1:0] cd,
                               input logic rdy, input logic st);
        bit pop;
        bit hs;
        bit drop;
        if (st) begin
            for (int j = 0; j < N; j++) mq[j].delete();
            m_valid     = 1'b0;
            m_rows_done = 1'b0;
            m_ovf       = 1'b0;
            m_rows      = 0;
        end else begin
            pop = 1'b1;
            for (int j = 0; j < N; j++) if (mq[j].size() == 0) pop = 1'b0;
            pop = pop && (!m_valid || rdy);
            hs  = m_valid && rdy;
            m_rows_done = 1'b0;
            if (hs) begin
                m_rows++;
                if (m_rows == N) begin
                    m_rows      = 0;
                    m_rows_done = 1'b1;
                end
            end
            drop = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (pop) m_data[j*D +: D] = mq[j].pop_front();
                if (cv[j]) begin
                    if (mq[j].size() < DEPTH) mq[j].push_back(cd[j*D +: D]);
                    else drop = 1'b1;
                end
            end
            if (pop) m_valid = 1'b1;
            else if (hs) m_valid = 1'b0;
            if (drop) m_ovf = OVF_BUILD;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".valid"}, W'(out_valid), W'(m_valid));
        check_eq({tag, ".data"},  out_data,      m_data);
        check_eq({tag, ".done"},  W'(rows_done), W'(m_rows_done));
        check_eq({tag, ".ovf"},   W'(ovf),       W'(m_ovf));
    endtask

    // Drive one cycle's inputs, clock, then compare just after the edge.
    task automatic step(input string tag, input logic [N-1:0] cv, input logic [W-1:0] cd,
                        input logic rdy, input logic st);
        col_valid = cv;
        col_data  = cd;
        out_ready = rdy;
        start     = st;
        @(posedge clk);
        model_clock(cv, cd, rdy, st);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b1;

        // Skewed 2x2 with the consumer always ready
        step("skew_c0", 2'b01, {32'h0, 32'h11}, 1'b1, 1'b0);
        step("skew_c1", 2'b11, {32'h12, 32'h21}, 1'b1, 1'b0);
        step("skew_c2", 2'b10, {32'h22, 32'h0}, 1'b1, 1'b0);
        check_eq("skew_row0", out_data, 64'h00000012_00000011);
        check_eq("skew_row0_valid", W'(out_valid), W'(1'b1));
        step("skew_c3", 2'b00, '0, 1'b1, 1'b0);
        check_eq("skew_row1", out_data, 64'h00000022_00000021);
        step("skew_c4", 2'b00, '0, 1'b1, 1'b0);
        check_eq("skew_rows_done", W'(rows_done), W'(1'b1));
        step("skew_c5", 2'b00, '0, 1'b1, 1'b0);

        // Backpressure: consumer stalls until cycle 8
        step("bp_start", 2'b00, '0, 1'b0, 1'b1);
        step("bp_c0", 2'b01, {32'h0, 32'h11}, 1'b0, 1'b0);
        step("bp_c1", 2'b11, {32'h12, 32'h21}, 1'b0, 1'b0);
        step("bp_c2", 2'b10, {32'h22, 32'h0}, 1'b0, 1'b0);
        for (int c = 3; c < 8; c++) begin
            step("bp_hold", 2'b00, '0, 1'b0, 1'b0);
            check_eq("bp_held", out_data, 64'h00000012_00000011);
        end
        step("bp_c8", 2'b00, '0, 1'b1, 1'b0);
        check_eq("bp_row1", out_data, 64'h00000022_00000021);
        step("bp_c9", 2'b00, '0, 1'b1, 1'b0);
        check_eq("bp_rows_done", W'(rows_done), W'(1'b1));

        // Overflow: five column-0 pushes into a four-entry FIFO
        step("ovf_start", 2'b00, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step("ovf_push", 2'b01, {32'h0, 32'hA0 + 32'(i)}, 1'b1, 1'b0);
            if (i == 3) check_eq("ovf_before_drop", W'(ovf), W'(1'b0));
        end
        check_eq("ovf_after_drop", W'(ovf), W'(OVF_BUILD));
        for (int i = 0; i < 4; i++) step("ovf_drain", 2'b10, {32'hB0 + 32'(i), 32'h0}, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("ovf_tail", 2'b00, '0, 1'b1, 1'b0);
        check_eq("ovf_last_row", out_data, 64'h000000B3_000000A3);
        check_eq("ovf_sticky", W'(ovf), W'(OVF_BUILD));
        step("ovf_clear", 2'b00, '0, 1'b1, 1'b1);
        check_eq("ovf_cleared", W'(ovf), W'(1'b0));

        // start flush with one column-0 entry buffered
        step("fl_push", 2'b01, {32'h0, 32'h55}, 1'b1, 1'b0);
        step("fl_start", 2'b00, '0, 1'b1, 1'b1);
        check_eq("fl_valid", W'(out_valid), W'(1'b0));
        step("fl_row", 2'b11, {32'h66, 32'h77}, 1'b1, 1'b0);
        step("fl_wait", 2'b00, '0, 1'b1, 1'b0);
        check_eq("fl_data", out_data, 64'h00000066_00000077);
        step("fl_row2", 2'b11, {32'h88, 32'h99}, 1'b1, 1'b0);
        step("fl_wait2", 2'b00, '0, 1'b1, 1'b0);
        step("fl_done", 2'b00, '0, 1'b1, 1'b0);
        check_eq("fl_rows_done", W'(rows_done), W'(1'b1));

        // Asynchronous reset while a row is presented
        step("ar_row", 2'b11, {32'hC1, 32'hC0}, 1'b0, 1'b0);
        step("ar_wait", 2'b00, '0, 1'b0, 1'b0);
        check_eq("ar_valid_before", W'(out_valid), W'(1'b1));
        #2;
        reset = 1'b0;
        #1;
        check_eq("ar_valid", W'(out_valid), W'(1'b0));
        check_eq("ar_data",  out_data,      '0);
        check_eq("ar_done",  W'(rows_done), W'(1'b0));
        check_eq("ar_ovf",   W'(ovf),       W'(1'b0));
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("ar_hold");
        reset = 1'b1;
        step("ar_after", 2'b11, {32'hD1, 32'hD0}, 1'b1, 1'b0);
        step("ar_after2", 2'b00, '0, 1'b1, 1'b0);
        check_eq("ar_after_data", out_data, 64'h000000D1_000000D0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 N'($urandom_range(0, 3)),
                 {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
